// File: rtl/rom_stream_feeder.sv
// Paces a valid/ready byte stream into the game loader's download interface,
// bracketing each file with a loader reset pulse and a trailing downloading hold.
module rom_stream_feeder #(
  parameter int GAP     = 4,
  parameter int TAIL    = 8,
  parameter int RST_CYC = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [21:0] file_len,
  input  logic [7:0]  file_type,
  input  logic        abort,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        loader_reset,
  output logic        downloading,
  output logic [7:0]  filetype,
  output logic [7:0]  indata,
  output logic        indata_clk,
  output logic [21:0] bytes_sent,
  output logic        busy,
  output logic        done,
  output logic        aborted
);

  typedef enum logic [1:0] {ST_IDLE, ST_LRST, ST_STREAM, ST_TAIL} state_t;

  state_t      state, state_next;
  logic [21:0] remaining;
  logic [3:0]  gap_cnt;
  logic [3:0]  tail_cnt;
  logic [1:0]  rst_cnt;
  logic        accept;
  logic        hs;

  // s_ready depends only on registered state, never on s_valid.
  assign s_ready = (state == ST_STREAM) && (gap_cnt == 4'd0) && (remaining != 22'd0);
  assign hs      = s_valid && s_ready;
  assign busy    = (state != ST_IDLE);
  assign accept  = (state == ST_IDLE) && start && !abort;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (accept) state_next = ST_LRST;
      ST_LRST:   if (rst_cnt == 2'd0) state_next = ST_STREAM;
      ST_STREAM: if (remaining == 22'd0 && gap_cnt == 4'd0) state_next = ST_TAIL;
      ST_TAIL:   if (tail_cnt == 4'd1) state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      remaining    <= '0;
      gap_cnt      <= '0;
      tail_cnt     <= '0;
      rst_cnt      <= '0;
      loader_reset <= 1'b0;
      downloading  <= 1'b0;
      filetype     <= '0;
      indata       <= '0;
      indata_clk   <= 1'b0;
      bytes_sent   <= '0;
      done         <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      state      <= state_next;
      indata_clk <= hs;
      done       <= 1'b0;

      // A handshake coinciding with abort is still honoured, since s_ready was offered.
      if (hs) begin
        indata     <= s_data;
        remaining  <= remaining - 22'd1;
        bytes_sent <= bytes_sent + 22'd1;
      end

      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            remaining    <= file_len;
            filetype     <= file_type;
            bytes_sent   <= '0;
            aborted      <= 1'b0;
            rst_cnt      <= 2'(RST_CYC - 1);
            loader_reset <= 1'b1;
            downloading  <= 1'b1;
          end
        end
        ST_LRST: begin
          if (rst_cnt == 2'd0) begin
            loader_reset <= 1'b0;
            gap_cnt      <= 4'd0;
          end else begin
            rst_cnt <= rst_cnt - 2'd1;
          end
        end
        ST_STREAM: begin
          if (hs)                  gap_cnt <= 4'(GAP - 1);
          else if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
          if (remaining == 22'd0 && gap_cnt == 4'd0) tail_cnt <= 4'(TAIL);
        end
        ST_TAIL: begin
          tail_cnt <= tail_cnt - 4'd1;
          if (tail_cnt == 4'd1) begin
            downloading <= 1'b0;
            done        <= 1'b1;
          end
        end
      endcase

      if (abort) begin
        aborted      <= 1'b1;
        downloading  <= 1'b0;
        loader_reset <= 1'b0;
        done         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rom_stream_feeder.sv
// Directed bench for rom_stream_feeder: long file, random source stalls,
// empty file, abort, ignored re-start and asynchronous reset mid-TAIL.
module tb_rom_stream_feeder;

  localparam int GAP     = 4;
  localparam int TAIL    = 8;
  localparam int RST_CYC = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [21:0] file_len = '0;
  logic [7:0]  file_type = '0;
  logic        abort = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready, loader_reset, downloading, indata_clk, busy, done, aborted;
  logic [7:0]  filetype, indata;
  logic [21:0] bytes_sent;

  rom_stream_feeder #(.GAP(GAP), .TAIL(TAIL), .RST_CYC(RST_CYC)) dut (
    .clk(clk), .resetn(resetn), .start(start), .file_len(file_len),
    .file_type(file_type), .abort(abort), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .loader_reset(loader_reset), .downloading(downloading),
    .filetype(filetype), .indata(indata), .indata_clk(indata_clk),
    .bytes_sent(bytes_sent), .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  // Per-file observation state, all written from the single initial block.
  int          cyc, strobes, min_sp, max_sp, last_strobe, first_strobe;
  int          lr_cnt, lr_last, rise_cyc, fall_cyc, done_cyc, done_cnt, dl_cnt;
  int          data_err, src_idx, done_bytes;
  bit          have_last, prev_dl, rand_valid;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] src_byte(input int i);
    return 8'(i * 7 + 3);
  endfunction

  task automatic clear_stats();
    strobes = 0; min_sp = 1000; max_sp = 0; have_last = 0; first_strobe = -1;
    lr_cnt = 0; lr_last = -1; rise_cyc = -1; fall_cyc = -1; done_cyc = -1;
    done_cnt = 0; dl_cnt = 0; data_err = 0; done_bytes = -1;
  endtask

  // One clock: observe outputs at the falling edge, then drive the source.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (indata_clk) begin
      strobes++;
      if (have_last) begin
        if (cyc - last_strobe < min_sp) min_sp = cyc - last_strobe;
        if (cyc - last_strobe > max_sp) max_sp = cyc - last_strobe;
      end else begin
        first_strobe = cyc;
      end
      have_last = 1;
      last_strobe = cyc;
      if (exp_q.size() == 0) data_err++;
      else begin
        exp_b = exp_q.pop_front();
        if (exp_b !== indata) data_err++;
      end
    end
    if (loader_reset) begin lr_cnt++; lr_last = cyc; end
    if (downloading) dl_cnt++;
    if (downloading && rise_cyc < 0) rise_cyc = cyc;
    if (prev_dl && !downloading) fall_cyc = cyc;
    prev_dl = downloading;
    if (done) begin done_cnt++; done_cyc = cyc; done_bytes = int'(bytes_sent); end
    start = 1'b0;
    abort = 1'b0;
    s_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
    s_data = src_byte(src_idx);
    if (s_valid && s_ready) begin
      exp_q.push_back(s_data);
      src_idx++;
    end
  endtask

  task automatic begin_file(input int len, input logic [7:0] ft);
    file_len = 22'(len);
    file_type = ft;
    start = 1'b1;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    bit seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      tick();
      if (done) seen = 1;
    end
    check({tag, "_done_seen"}, seen, 1);
  endtask

  task automatic run_until_strobes(input string tag, input int n, input int budget);
    for (int c = 0; c < budget && strobes < n; c++) tick();
    check({tag, "_strobes_reached"}, strobes, n);
  endtask

  initial begin
    cyc = 0; src_idx = 0; prev_dl = 0; rand_valid = 0;
    clear_stats();

    // Reset state
    tick(); tick();
    check("rst_flags", {25'd0, s_ready, loader_reset, downloading, indata_clk, busy, done, aborted}, 0);
    check("rst_bytes_sent", bytes_sent, 0);
    check("rst_filetype", filetype, 0);
    resetn = 1'b1;
    tick();

    // 16-byte header + 16 KiB PRG, source always valid
    clear_stats();
    begin_file(16400, 8'h02);
    run_until_done("long", 70000);
    check("long_strobes", strobes, 16400);
    check("long_min_spacing", min_sp, GAP);
    check("long_max_spacing", max_sp, GAP);
    check("long_bytes_at_done", done_bytes, 16400);
    check("long_data_err", data_err, 0);
    check("long_queue_empty", exp_q.size(), 0);
    check("long_lr_cycles", lr_cnt, RST_CYC);
    check("long_lr_to_first_strobe", first_strobe - lr_last, 2);
    // Falls after the final gap drains plus the TAIL countdown.
    check("long_dl_fall_after_last", fall_cyc - last_strobe, GAP + TAIL);
    check("long_done_with_fall", done_cyc, fall_cyc);
    check("long_latency", done_cyc - rise_cyc, 1 + RST_CYC + GAP * 16400 + TAIL);
    check("long_filetype", filetype, 8'h02);

    // 37 bytes with a stalling source
    clear_stats();
    rand_valid = 1;
    tick();
    begin_file(37, 8'h01);
    run_until_done("rand", 3000);
    rand_valid = 0;
    check("rand_strobes", strobes, 37);
    check("rand_min_spacing_ge_gap", min_sp >= GAP, 1);
    check("rand_data_err", data_err, 0);
    check("rand_queue_empty", exp_q.size(), 0);
    check("rand_bytes_at_done", done_bytes, 37);

    // Empty file
    clear_stats();
    tick();
    begin_file(0, 8'h04);
    run_until_done("empty", 100);
    for (int i = 0; i < 10; i++) tick();
    check("empty_strobes", strobes, 0);
    check("empty_done_count", done_cnt, 1);
    check("empty_dl_cycles", dl_cnt, RST_CYC + TAIL + 1);

    // Abort after byte 5 of 100
    clear_stats();
    tick();
    begin_file(100, 8'h02);
    run_until_strobes("abort", 5, 200);
    abort = 1'b1;
    tick();
    check("abort_downloading", downloading, 0);
    check("abort_aborted", aborted, 1);
    check("abort_busy", busy, 0);
    check("abort_s_ready", s_ready, 0);
    check("abort_bytes_sent", bytes_sent, 5);
    for (int i = 0; i < 30; i++) tick();
    check("abort_no_done", done_cnt, 0);
    check("abort_no_more_strobes", strobes, 5);
    clear_stats();
    begin_file(3, 8'h08);
    tick();
    check("restart_aborted_clear", aborted, 0);
    run_until_done("restart", 200);
    check("restart_bytes", done_bytes, 3);
    check("restart_filetype", filetype, 8'h08);
    check("restart_data_err", data_err, 0);

    // start and abort together while idle: abort wins
    tick();
    begin_file(10, 8'h01);
    abort = 1'b1;
    tick();
    check("start_abort_busy", busy, 0);
    check("start_abort_aborted", aborted, 1);
    check("start_abort_filetype", filetype, 8'h08);

    // Re-pulsed start during STREAM, then reset mid-TAIL
    clear_stats();
    begin_file(20, 8'h04);
    run_until_strobes("restream", 3, 100);
    begin_file(5, 8'h01);
    run_until_strobes("restream_all", 20, 200);
    for (int i = 0; i < 6; i++) tick();
    check("tail_downloading", downloading, 1);
    check("tail_bytes_sent", bytes_sent, 20);
    check("tail_filetype", filetype, 8'h04);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_flags", {25'd0, s_ready, loader_reset, downloading, indata_clk, busy, done, aborted}, 0);
    check("async_rst_bytes", bytes_sent, 0);
    check("async_rst_filetype", filetype, 0);
    check("async_rst_indata", indata, 0);
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("post_rst_no_done", done_cnt, 0);
    check("post_rst_no_strobe", strobes, 20);
    check("post_rst_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/rom_stream_feeder.md
# rom_stream_feeder

Upstream pacing stage for the game loader. Takes a file byte stream from the storage reader (SD/flash sector engine) over a valid/ready handshake and replays it as the loader's `downloading` / `indata` / `indata_clk` / `filetype` interface. It guarantees a minimum gap between byte strobes so SDRAM writes complete, and it brackets every file with a loader reset pulse and a trailing `downloading` hold.

## Interface
Parameters:
- `GAP`, 4: minimum clk cycles between successive `indata_clk` pulses; legal range 2..15.
- `TAIL`, 8: cycles `downloading` stays high after the last strobe; legal range 1..15.
- `RST_CYC`, 2: cycles `loader_reset` is held before streaming; legal range 1..3.

Ports:
- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a file; ignored unless idle.
- `file_len`  in  22  file length in bytes; latched on an accepted `start`.
- `file_type`  in  8  loader filetype bits (bios/nes/fds/nsf); latched on an accepted `start`.
- `abort`  in  1  terminates the transfer immediately.
- `s_data`  in  8  source byte.
- `s_valid`  in  1  source byte valid.
- `s_ready`  out  1  feeder accepts `s_data` this cycle.
- `loader_reset`  out  1  active-high reset to the loader.
- `downloading`  out  1  file transfer in progress.
- `filetype`  out  8  latched `file_type`.
- `indata`  out  8  byte to the loader.
- `indata_clk`  out  1  one-cycle byte strobe.
- `bytes_sent`  out  22  strobes issued for the current file.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at normal completion.
- `aborted`  out  1  sticky; set by `abort`, cleared by the next accepted `start`.

## Operation
- States: IDLE, LRST, STREAM, TAIL.
- Reset values: state IDLE; every output 0; internal counters 0.
- IDLE, on `start`:
  - Latch `file_len` into `remaining` and `file_type` into `filetype`.
  - Clear `bytes_sent` and `aborted`.
  - Go to LRST.
- LRST:
  - `loader_reset`=1 and `downloading`=1 for `RST_CYC` cycles, then go to STREAM.
  - The gap counter loads 0, so the first byte can be accepted on the first STREAM cycle.
- STREAM:
  - `s_ready` = (gap counter == 0) && (`remaining` != 0).
  - A handshake is `s_valid && s_ready`. On a handshake: register `indata` <= `s_data`, pulse `indata_clk` on the next cycle, decrement `remaining`, increment `bytes_sent`, load the gap counter with `GAP-1`.
  - The gap counter decrements to 0 and saturates there.
  - When `remaining` == 0 and the gap counter == 0, go to TAIL with the tail counter at `TAIL`.
- TAIL:
  - `downloading` stays 1 while the tail counter counts down.
  - When it reaches 0: `downloading` <= 0, `done` pulses for 1 cycle, go to IDLE.
  - `filetype` holds its value until the next `start`.
- `file_len` == 0: LRST -> STREAM -> TAIL with no strobe. `done` is still issued.
- `abort` in any non-IDLE state: on the next edge go to IDLE with `downloading`=0, `loader_reset`=0, `s_ready`=0 and `aborted`=1. No `done` pulse. A strobe already registered still completes its single cycle.
- `start` while busy is ignored. `start` and `abort` together in IDLE: `abort` wins, `aborted`=1, state stays IDLE.
- Async reset mid-transfer: all outputs drop to 0 immediately; no strobe or `done` is emitted afterwards.
- Width rules:
  - `remaining` and `bytes_sent` are 22 bits (max 4 MiB − 1) and never wrap, because `remaining` gates `s_ready`.
  - The gap counter is 4 bits and the tail counter is 4 bits.

## Timing
- Handshake at edge N: `indata` is valid and `indata_clk`=1 during cycle N+1 only; `indata` holds until the next handshake.
- The next handshake is no earlier than edge N+GAP, so strobe spacing is ≥ `GAP` cycles. With `s_valid` held high the spacing is exactly `GAP`.
- `s_ready` is a registered function of the state and counters; it has no combinational path from `s_valid`.
- `downloading` rises at the `start` edge + 1. It is high through the last strobe plus `TAIL` cycles, then falls in the same cycle `done` pulses.
- Minimum file latency, `start` to `done`: 1 + `RST_CYC` + `GAP`·`file_len` + `TAIL` + small fixed overhead (≤2 cycles).

## Test plan
- 16-byte header plus 16 KiB PRG (`file_len`=16400, type 0x02), `s_valid` always 1, GAP=4:
  - Exactly 16400 strobes, each 4 cycles apart.
  - `bytes_sent`=16400 at `done`.
  - `downloading` falls 8 cycles after the last strobe.
  - `loader_reset` is high for 2 cycles before the first strobe.
- Random `s_valid` deassertion (50%), `file_len`=37:
  - Strobe spacing ≥ 4 in every case.
  - `indata` sequence equals the source sequence.
  - No byte is dropped or duplicated.
- `file_len`=0:
  - No `indata_clk`.
  - `done` pulses exactly once.
  - `downloading` is high for `RST_CYC`+`TAIL`+overhead cycles.
- `abort` asserted after byte 5 of 100:
  - `downloading`=0 on the next cycle.
  - `aborted`=1 and no `done`.
  - `bytes_sent`=5 (6 if the handshake coincided).
  - A following `start` clears `aborted` and runs normally.
- `start` re-pulsed during STREAM, then `resetn` asserted mid-TAIL:
  - The second `start` is ignored.
  - On reset, all outputs are 0 asynchronously and the state is IDLE after release.
